// File: rtl/mesh_out_port_arb.sv
// ---------------------------------------------------------------------------
// mesh_out_port_arb
//
// Shares one mesh-router output link among NUM_REQ input FIFOs. A packet is
// locked onto the link from its head flit to its tail flit (wormhole), and
// packets are chosen round-robin. Flits are popped one at a time from the
// winning FIFO, whose read data appears one cycle after the pop strobe. Each
// flit is then registered toward the downstream FIFO.
//
// Handshake: a flit is transferred downstream in every cycle where out_wr_en
// is high. The downstream cannot stall a write in progress. It can only
// signal out_afull, which is sampled when a pop is about to be issued, and it
// must be able to absorb the single flit already in flight.
//
// Ports
//   clk          clock
//   rst_n        asynchronous reset, active-high (legacy name)
//   req          per input: the head flit at the FIFO front targets this port
//   fifo_empty   per-input FIFO empty flags
//   fifo_data    flattened FIFO read data, input i at [i*NUM_BITS +: NUM_BITS]
//   out_afull    downstream has at most one free entry
//   rd_en        one-hot pop strobe to the owning input FIFO
//   out_wr_en    registered downstream write strobe
//   out_data     registered flit to downstream (holds its value between writes)
//   grant_id     index of the current (or most recent) owner
//   busy         a packet is locked on the port
//   dbg_state    FSM state for observation: 0 IDLE, 1 READ, 2 XFER, 3 WAIT
//   dbg_rr_ptr   round-robin start index for the next arbitration
// ---------------------------------------------------------------------------
module mesh_out_port_arb #(
    parameter int NUM_REQ  = 5,
    parameter int NUM_BITS = 64,
    parameter int IDW      = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          fifo_empty,
    input  logic [NUM_REQ*NUM_BITS-1:0] fifo_data,
    input  logic                        out_afull,
    output logic [NUM_REQ-1:0]          rd_en,
    output logic                        out_wr_en,
    output logic [NUM_BITS-1:0]         out_data,
    output logic [IDW-1:0]              grant_id,
    output logic                        busy,
    output logic [1:0]                  dbg_state,
    output logic [IDW-1:0]              dbg_rr_ptr
);

    localparam int CW = IDW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_XFER = 2'd2,
        ST_WAIT = 2'd3
    } state_e;

    state_e                state_q,     state_d;
    logic [IDW-1:0]        grant_id_q,  grant_id_d;
    logic [IDW-1:0]        rr_ptr_q,    rr_ptr_d;
    logic                  busy_q,      busy_d;
    logic                  out_wr_en_q, out_wr_en_d;
    logic [NUM_BITS-1:0]   out_data_q,  out_data_d;

    // ------------------------------------------------------------------
    // Round-robin pick: first eligible input scanning from rr_ptr upward
    // with wrap at NUM_REQ-1.
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] eligible;
    logic               arb_found;
    logic [IDW-1:0]     arb_pick;
    logic [CW-1:0]      arb_cand;

    always_comb begin
        eligible  = req & ~fifo_empty;
        arb_found = 1'b0;
        arb_pick  = '0;
        arb_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_cand = {1'b0, rr_ptr_q} + CW'(k);
            if (arb_cand >= CW'(NUM_REQ)) begin
                arb_cand = arb_cand - CW'(NUM_REQ);
            end
            if (!arb_found && eligible[arb_cand[IDW-1:0]]) begin
                arb_found = 1'b1;
                arb_pick  = arb_cand[IDW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Owner-side views
    // ------------------------------------------------------------------
    logic [NUM_BITS-1:0] cur_flit;
    logic                owner_ready;
    logic [IDW-1:0]      grant_next;

    always_comb begin
        cur_flit    = fifo_data[int'(grant_id_q) * NUM_BITS +: NUM_BITS];
        owner_ready = !fifo_empty[grant_id_q] && !out_afull;
        // The finishing owner becomes the lowest priority next time.
        if (grant_id_q == IDW'(NUM_REQ - 1)) begin
            grant_next = '0;
        end else begin
            grant_next = grant_id_q + IDW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        busy_d      = busy_q;
        out_wr_en_d = 1'b0;
        out_data_d  = out_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_found && !out_afull) begin
                    grant_id_d = arb_pick;
                    busy_d     = 1'b1;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                // Pop strobe is decoded from this state; data is ready next cycle.
                state_d = ST_XFER;
            end
            ST_XFER: begin
                out_data_d  = cur_flit;
                out_wr_en_d = 1'b1;
                if (cur_flit[NUM_BITS-1]) begin
                    busy_d   = 1'b0;
                    rr_ptr_d = grant_next;
                    state_d  = ST_IDLE;
                end else if (owner_ready) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Lock held; other requests are ignored until the tail arrives.
                if (owner_ready) begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Legacy naming: rst_n is active-high here.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= ST_IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            busy_q      <= 1'b0;
            out_wr_en_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
            out_wr_en_q <= out_wr_en_d;
            out_data_q  <= out_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        rd_en = '0;
        if (state_q == ST_READ) begin
            rd_en[grant_id_q] = 1'b1;
        end
    end

    assign out_wr_en  = out_wr_en_q;
    assign out_data   = out_data_q;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;
    assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_mesh_out_port_arb.sv
module tb_mesh_out_port_arb;

  localparam int N   = 5;
  localparam int W   = 64;
  localparam int IDW = 3;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   fifo_empty;
  logic [N*W-1:0] fifo_data;
  logic           out_afull;
  logic [N-1:0]   rd_en;
  logic           out_wr_en;
  logic [W-1:0]   out_data;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic [1:0]     dbg_state;
  logic [IDW-1:0] dbg_rr_ptr;

  always #5 clk = ~clk;

  mesh_out_port_arb #(.NUM_REQ(N), .NUM_BITS(W), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .out_afull  (out_afull),
    .rd_en      (rd_en),
    .out_wr_en  (out_wr_en),
    .out_data   (out_data),
    .grant_id   (grant_id),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- environment: input FIFOs ----------------
  logic [W-1:0] fq [N][$];
  logic [W-1:0] data_reg [N];
  int           pend_id[$];
  logic [W-1:0] pend_dat[$];
  logic [N-1:0] req_en;
  logic         afull_drv;
  logic [N-1:0] pop_mask;
  int           gen_left [N];
  int           gen_seq;

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;
  int           cyc;
  int           m_next_dec;
  bit           m_locked;
  bit           m_have_flit;
  int           m_gid;
  int           m_rr;
  logic [W-1:0] m_flit;
  logic [W-1:0] m_last;
  logic [N-1:0] rd_sched [int];
  logic [W-1:0] wr_sched [int];
  int           wr_cycs[$];
  int           last_rd_cyc;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [W-1:0] d);
    pend_id.push_back(id);
    pend_dat.push_back(d);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i]         = (fq[i].size() == 0);
      req[i]                = req_en[i] && (fq[i].size() > 0);
      fifo_data[i*W +: W]   = data_reg[i];
    end
    out_afull = afull_drv;
  endtask

  // Packet-level schedule model: each arbitration/continuation decision at
  // cycle c books a pop at c+1 and the matching downstream write at c+3.
  task automatic model_and_compare();
    logic [N-1:0] exp_rd;
    bit           exp_wr;
    logic [N-1:0] elig;
    bool_t_dummy: begin end
    exp_rd = rd_sched.exists(cyc) ? rd_sched[cyc] : '0;
    exp_wr = wr_sched.exists(cyc);
    if (exp_wr) m_last = wr_sched[cyc];

    chk("rd_en",      64'(rd_en),      64'(exp_rd));
    chk("out_wr_en",  64'(out_wr_en),  64'(exp_wr));
    chk("out_data",   out_data,        m_last);
    chk("busy",       64'(busy),       64'(m_locked));
    chk("grant_id",   64'(grant_id),   64'(m_gid));
    chk("rr_ptr",     64'(dbg_rr_ptr), 64'(m_rr));
    chk("rd_to_empty", 64'(rd_en & fifo_empty), 64'(0));
    chk("rd_onehot",  64'($onehot0(rd_en)), 64'(1));

    if (out_wr_en) begin
      wr_cycs.push_back(cyc);
      if (exp_q.size() > 0) chk("literal_flit", out_data, exp_q.pop_front());
    end
    if (rd_en != '0) last_rd_cyc = cyc;

    if (exp_rd != '0 && fq[m_gid].size() > 0) m_flit = fq[m_gid][0];

    if (cyc == m_next_dec) begin
      if (!m_locked) begin
        for (int i = 0; i < N; i++) elig[i] = req_en[i] && (fq[i].size() > 0);
        m_next_dec = cyc + 1;
        if (elig != '0 && !afull_drv) begin
          for (int k = N - 1; k >= 0; k--) begin
            if (elig[(m_rr + k) % N]) m_gid = (m_rr + k) % N;
          end
          m_locked    = 1'b1;
          m_have_flit = 1'b1;
          rd_sched[cyc + 1] = N'(1) << m_gid;
          m_next_dec  = cyc + 2;
        end
      end else begin
        bit may_pop;
        bit done;
        done = 1'b0;
        if (m_have_flit) begin
          wr_sched[cyc + 1] = m_flit;
          m_have_flit = 1'b0;
          if (m_flit[W-1]) begin
            m_locked   = 1'b0;
            m_rr       = (m_gid + 1) % N;
            m_next_dec = cyc + 1;
            done       = 1'b1;
          end
        end
        if (!done) begin
          may_pop = (fq[m_gid].size() > 0) && !afull_drv;
          if (may_pop) begin
            rd_sched[cyc + 1] = N'(1) << m_gid;
            m_have_flit = 1'b1;
            m_next_dec  = cyc + 2;
          end else begin
            m_next_dec  = cyc + 1;
          end
        end
      end
    end
    if (rd_sched.exists(cyc)) rd_sched.delete(cyc);
    if (wr_sched.exists(cyc)) wr_sched.delete(cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (pop_mask[i] && fq[i].size() > 0) data_reg[i] = fq[i].pop_front();
    end
    while (pend_id.size() > 0) begin
      int id;
      id = pend_id.pop_front();
      fq[id].push_back(pend_dat.pop_front());
    end
    drive();
    @(negedge clk);
    model_and_compare();
    pop_mask = rd_en;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Called at a negedge; asserts reset, checks the asynchronous clear, and
  // restarts the model and environment from scratch.
  task automatic do_reset();
    rst_n  = 1'b1;
    req_en = '0;
    req    = '0;
    #1;
    chk("rst_rd_en",     64'(rd_en),      64'(0));
    chk("rst_out_wr_en", 64'(out_wr_en),  64'(0));
    chk("rst_out_data",  out_data,        64'(0));
    chk("rst_grant_id",  64'(grant_id),   64'(0));
    chk("rst_busy",      64'(busy),       64'(0));
    chk("rst_rr_ptr",    64'(dbg_rr_ptr), 64'(0));
    for (int i = 0; i < N; i++) begin
      fq[i].delete();
      data_reg[i] = '0;
    end
    pend_id.delete();
    pend_dat.delete();
    exp_q.delete();
    pop_mask    = '0;
    afull_drv   = 1'b0;
    drive();
    m_locked    = 1'b0;
    m_have_flit = 1'b0;
    m_gid       = 0;
    m_rr        = 0;
    m_last      = '0;
    m_flit      = '0;
    rd_sched.delete();
    wr_sched.delete();
    repeat (2) @(negedge clk);
    rst_n      = 1'b0;
    m_next_dec = cyc + 1;
  endtask

  task automatic rand_push(input int i);
    logic tail;
    if (gen_left[i] == 0) gen_left[i] = $urandom_range(1, 4);
    gen_left[i]--;
    tail = (gen_left[i] == 0);
    gen_seq++;
    push(i, {tail, 7'(i), 24'(gen_seq), 32'($urandom)});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] tail_bit;
    int           c0;
    bit           seen;
    tail_bit = 64'h8000_0000_0000_0000;
    checks = 0; errors = 0; cyc = 0; gen_seq = 0; last_rd_cyc = 0;
    for (int i = 0; i < N; i++) gen_left[i] = 0;
    rst_n = 1'b0; req = '0; fifo_empty = '1; fifo_data = '0; out_afull = 1'b0;
    req_en = '0; afull_drv = 1'b0; pop_mask = '0;
    #2;
    do_reset();

    // Round-robin from index 0, then again on refill.
    req_en = '1;
    for (int i = 0; i < N; i++) begin
      push(i, tail_bit | 64'(i));
      exp_q.push_back(tail_bit | 64'(i));
    end
    run(25);
    chk("rr_first_pass_done", 64'(exp_q.size()), 64'(0));
    for (int i = 0; i < N; i++) begin
      push(i, tail_bit | 64'(i));
      exp_q.push_back(tail_bit | 64'(i));
    end
    run(25);
    chk("rr_refill_done", 64'(exp_q.size()), 64'(0));
    chk("rr_ptr_after_refill", 64'(dbg_rr_ptr), 64'(0));

    // Single requester, single-flit packet: latency and rr update.
    req_en = 5'b00001;
    push(0, 64'h8000_0000_0000_00AA);
    exp_q.push_back(64'h8000_0000_0000_00AA);
    wr_cycs.delete();
    c0 = cyc + 1;
    run(8);
    chk("single_done", 64'(exp_q.size()), 64'(0));
    chk("single_rd_cycle", 64'(last_rd_cyc), 64'(c0 + 1));
    chk("single_wr_cycle", 64'(wr_cycs.size() > 0 ? wr_cycs[0] : -1), 64'(c0 + 3));
    chk("single_rr_ptr", 64'(dbg_rr_ptr), 64'(1));
    chk("single_busy_off", 64'(busy), 64'(0));

    // Wormhole lock: input 2 three-flit packet beats input 3 (rr=1).
    req_en = 5'b01100;
    push(2, 64'h0000_0000_0000_0201);
    push(2, 64'h0000_0000_0000_0202);
    push(2, 64'h8000_0000_0000_0203);
    push(3, 64'h8000_0000_0000_0301);
    exp_q.push_back(64'h0000_0000_0000_0201);
    exp_q.push_back(64'h0000_0000_0000_0202);
    exp_q.push_back(64'h8000_0000_0000_0203);
    exp_q.push_back(64'h8000_0000_0000_0301);
    wr_cycs.delete();
    run(20);
    chk("worm_done", 64'(exp_q.size()), 64'(0));
    chk("worm_gap1", 64'(wr_cycs.size() >= 3 ? wr_cycs[1] - wr_cycs[0] : -1), 64'(2));
    chk("worm_gap2", 64'(wr_cycs.size() >= 3 ? wr_cycs[2] - wr_cycs[1] : -1), 64'(2));
    chk("worm_rr_ptr", 64'(dbg_rr_ptr), 64'(4));

    // Starvation mid-packet on input 2.
    req_en = 5'b00100;
    push(2, 64'h0000_0000_0000_0211);
    exp_q.push_back(64'h0000_0000_0000_0211);
    exp_q.push_back(64'h8000_0000_0000_0212);
    run(6);
    chk("starve_state_wait", 64'(dbg_state), 64'(3));
    chk("starve_busy", 64'(busy), 64'(1));
    chk("starve_no_rd", 64'(rd_en), 64'(0));
    push(2, 64'h8000_0000_0000_0212);
    step();
    step();
    chk("starve_resume_rd", 64'(rd_en), 64'(5'b00100));
    run(6);
    chk("starve_done", 64'(exp_q.size()), 64'(0));

    // Backpressure: nothing popped while out_afull, then 4 then 1 (rr=3).
    afull_drv = 1'b1;
    req_en = '1;
    push(1, 64'h8000_0000_0000_0501);
    push(4, 64'h8000_0000_0000_0504);
    exp_q.push_back(64'h8000_0000_0000_0504);
    exp_q.push_back(64'h8000_0000_0000_0501);
    run(6);
    chk("bp_no_rd", 64'(rd_en), 64'(0));
    chk("bp_idle", 64'(busy), 64'(0));
    afull_drv = 1'b0;
    step();
    step();
    chk("bp_release_rd", 64'(rd_en), 64'(5'b10000));
    run(12);
    chk("bp_done", 64'(exp_q.size()), 64'(0));

    // Reset during XFER of a multi-flit packet on input 3.
    req_en = 5'b01000;
    push(3, 64'h0000_0000_0000_0601);
    push(3, 64'h0000_0000_0000_0602);
    push(3, 64'h8000_0000_0000_0603);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = (rd_en[3] == 1'b1);
    end
    chk("rst_test_saw_rd", 64'(seen), 64'(1));
    step();
    chk("rst_test_in_xfer", 64'(dbg_state), 64'(2));
    do_reset();
    req_en = 5'b10001;
    push(4, 64'h8000_0000_0000_0704);
    push(0, 64'h8000_0000_0000_0700);
    exp_q.push_back(64'h8000_0000_0000_0700);
    exp_q.push_back(64'h8000_0000_0000_0704);
    run(12);
    chk("post_rst_done", 64'(exp_q.size()), 64'(0));

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0 && fq[i].size() < 7) rand_push(i);
      end
      if ($urandom_range(0, 7) == 0) req_en = N'($urandom);
      afull_drv = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
